// File: rtl/bus_demux_writer.sv
// Purpose : 1-to-8 write demultiplexer; commits one staged byte into one of eight held destination registers.
// Latency : accept edge -> data_outN/load_strobe visible 1 clk; accept-to-accept spacing 2 + SETTLE_CYCLES clks.
// Backpressure: write_ready (registered) is high only in IDLE; write_valid while not ready is ignored.
//
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   select, data_in       - destination index and byte, captured on accept
//   write_valid/ready     - request handshake
//   data_out0..7          - held destination registers (RESET_VALUE after reset)
//   load_strobe           - one-cycle commit pulse, bit N marks data_outN updating
//   busy                  - high while a write is committing or settling
//   broadcast             - only with DEMUX_BROADCAST_EN: write all eight destinations
//
// Optional feature macro: DEMUX_BROADCAST_EN (adds the broadcast input).

module bus_demux_writer #(
    parameter int unsigned            WIDTH         = 8,
    parameter logic [WIDTH-1:0]       RESET_VALUE   = '0,
    parameter int unsigned            SETTLE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] data_in,
`ifdef DEMUX_BROADCAST_EN
    input  logic             broadcast,
`endif
    input  logic             write_valid,
    output logic             write_ready,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic [WIDTH-1:0] data_out2,
    output logic [WIDTH-1:0] data_out3,
    output logic [WIDTH-1:0] data_out4,
    output logic [WIDTH-1:0] data_out5,
    output logic [WIDTH-1:0] data_out6,
    output logic [WIDTH-1:0] data_out7,
    output logic [7:0]       load_strobe,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Staged request, captured on the accept edge.
    typedef struct packed {
        logic             bcast;
        logic [2:0]       sel;
        logic [WIDTH-1:0] dat;
    } stage_t;

    // Counter counts down to zero, so entry value is one less than the wait.
    localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    state_t           state;
    stage_t           stage;
    logic [3:0]       settle_cnt;
    logic [WIDTH-1:0] regs [8];
    logic             bcast_in;

`ifdef DEMUX_BROADCAST_EN
    assign bcast_in = broadcast;
`else
    assign bcast_in = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            write_ready <= 1'b0;
            busy        <= 1'b0;
            load_strobe <= '0;
            stage       <= '0;
            settle_cnt  <= '0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else begin
            // Strobe is a single-cycle pulse; only COMMIT raises it.
            load_strobe <= '0;
            case (state)
                IDLE: begin
                    if (write_valid && write_ready) begin
                        stage.bcast <= bcast_in;
                        stage.sel   <= select;
                        stage.dat   <= data_in;
                        state       <= COMMIT;
                        write_ready <= 1'b0;
                        busy        <= 1'b1;
                    end else begin
                        // Also covers the first edge after reset release.
                        write_ready <= 1'b1;
                    end
                end
                COMMIT: begin
                    if (stage.bcast) begin
                        for (int i = 0; i < 8; i++) begin
                            regs[i] <= stage.dat;
                        end
                        load_strobe <= 8'hFF;
                    end else begin
                        regs[stage.sel] <= stage.dat;
                        load_strobe     <= 8'b1 << stage.sel;
                    end
                    if (SETTLE_CYCLES > 0) begin
                        state      <= SETTLE;
                        settle_cnt <= SETTLE_LOAD;
                    end else begin
                        state       <= IDLE;
                        write_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state       <= IDLE;
                        write_ready <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    write_ready <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    assign data_out0 = regs[0];
    assign data_out1 = regs[1];
    assign data_out2 = regs[2];
    assign data_out3 = regs[3];
    assign data_out4 = regs[4];
    assign data_out5 = regs[5];
    assign data_out6 = regs[6];
    assign data_out7 = regs[7];

endmodule

// File: tb/tb_bus_demux_writer.sv
// Purpose : self-checking bench for bus_demux_writer (table vectors, corner sequences, random traffic).
// Latency : reference model predicts outputs from accept timing (commit one edge after accept).
// Backpressure: requester holds valid/select/data until write_ready is seen at an edge.

module tb_bus_demux_writer;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] select;
    logic [7:0] data_in;
    logic       write_valid;
    logic       write_ready;
    logic [7:0] dout [8];
    logic [7:0] load_strobe;
    logic       busy;
`ifdef DEMUX_BROADCAST_EN
    logic       broadcast;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_demux_writer #(
        .WIDTH(8),
        .RESET_VALUE(8'h00),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .select(select),
        .data_in(data_in),
`ifdef DEMUX_BROADCAST_EN
        .broadcast(broadcast),
`endif
        .write_valid(write_valid),
        .write_ready(write_ready),
        .data_out0(dout[0]),
        .data_out1(dout[1]),
        .data_out2(dout[2]),
        .data_out3(dout[3]),
        .data_out4(dout[4]),
        .data_out5(dout[5]),
        .data_out6(dout[6]),
        .data_out7(dout[7]),
        .load_strobe(load_strobe),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: timing derived from "edges since the last accept".
    // age 0 = accept edge, age 1 = commit edge; busy while age <= S.
    localparam int unsigned NONE = 1000;
    int unsigned m_age;
    int unsigned m_age_nx;
    logic [2:0]  m_sel, m_sel_nx;
    logic [7:0]  m_dat, m_dat_nx;
    logic        m_bc,  m_bc_nx;
    logic        m_acc;
    logic [7:0]  m_mem [8];
    logic [7:0]  m_strobe;
    logic        m_busy, m_ready;

    assign m_acc    = write_valid && m_ready;
    assign m_age_nx = m_acc ? 0 : ((m_age < NONE) ? m_age + 1 : m_age);
    assign m_sel_nx = m_acc ? select  : m_sel;
    assign m_dat_nx = m_acc ? data_in : m_dat;
`ifdef DEMUX_BROADCAST_EN
    assign m_bc_nx  = m_acc ? broadcast : m_bc;
`else
    assign m_bc_nx  = 1'b0;
`endif

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_age    <= NONE;
            m_sel    <= '0;
            m_dat    <= '0;
            m_bc     <= 1'b0;
            m_strobe <= '0;
            m_busy   <= 1'b0;
            m_ready  <= 1'b0;
            for (int i = 0; i < 8; i++) m_mem[i] <= 8'h00;
        end else begin
            m_age    <= m_age_nx;
            m_sel    <= m_sel_nx;
            m_dat    <= m_dat_nx;
            m_bc     <= m_bc_nx;
            m_strobe <= '0;
            if (m_age_nx == 1) begin
                if (m_bc_nx) begin
                    for (int i = 0; i < 8; i++) m_mem[i] <= m_dat_nx;
                    m_strobe <= 8'hFF;
                end else begin
                    m_mem[m_sel_nx] <= m_dat_nx;
                    m_strobe        <= 8'b1 << m_sel_nx;
                end
            end
            m_busy  <= (m_age_nx <= S);
            m_ready <= !(m_age_nx <= S);
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", {31'b0, write_ready}, {31'b0, m_ready});
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("strobe", {24'b0, load_strobe}, {24'b0, m_strobe});
            for (int i = 0; i < 8; i++) chk($sformatf("data_out%0d", i), {24'b0, dout[i]}, {24'b0, m_mem[i]});
        end
    end

    // Waits (bounded) until the held request is accepted; returns the accept edge number.
    task automatic wait_accept(output int at);
        bit r;
        bit done;
        at   = -1;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            r = write_ready;
            @(posedge clk);
            #1;
            if (r) begin
                at   = cyc;
                done = 1'b1;
            end
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_write(input logic [2:0] s, input logic [7:0] d,
                            input logic [7:0] exp_strobe, input logic [7:0] exp_val);
        int at;
        write_valid = 1'b1;
        select      = s;
        data_in     = d;
        wait_accept(at);
        write_valid = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("tbl_strobe_sel%0d", s), {24'b0, load_strobe}, {24'b0, exp_strobe});
        chk($sformatf("tbl_value_sel%0d", s), {24'b0, dout[s]}, {24'b0, exp_val});
        @(posedge clk);
        #1;
        chk("tbl_strobe_cleared", {24'b0, load_strobe}, 32'd0);
    endtask

    typedef struct {
        logic [2:0] sel;
        logic [7:0] dat;
        logic [7:0] exp_strobe;
        logic [7:0] exp_val;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int  a1, a2;
        bit  r, took;

        tbl[0] = '{3'd3, 8'hA5, 8'b0000_1000, 8'hA5};
        tbl[1] = '{3'd0, 8'h11, 8'b0000_0001, 8'h11};
        tbl[2] = '{3'd0, 8'h22, 8'b0000_0001, 8'h22};  // overwrite
        tbl[3] = '{3'd0, 8'h22, 8'b0000_0001, 8'h22};  // same value still strobes
        tbl[4] = '{3'd7, 8'h80, 8'b1000_0000, 8'h80};
        tbl[5] = '{3'd1, 8'hFF, 8'b0000_0010, 8'hFF};
        tbl[6] = '{3'd2, 8'h00, 8'b0000_0100, 8'h00};
        tbl[7] = '{3'd4, 8'h69, 8'b0001_0000, 8'h69};

        reset_n     = 1'b0;
        write_valid = 1'b0;
        select      = '0;
        data_in     = '0;
`ifdef DEMUX_BROADCAST_EN
        broadcast   = 1'b0;
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, write_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_strobe", {24'b0, load_strobe}, 32'd0);
        chk("rst_dout3", {24'b0, dout[3]}, 32'd0);
        chk_en  = 1'b1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", {31'b0, write_ready}, 32'd1);

        // Table-driven single writes.
        for (int i = 0; i < 8; i++) do_write(tbl[i].sel, tbl[i].dat, tbl[i].exp_strobe, tbl[i].exp_val);
        chk("dout3_kept", {24'b0, dout[3]}, 32'hA5);
        chk("dout0_final", {24'b0, dout[0]}, 32'h22);

        // Handshake stall: valid held across two requests.
        write_valid = 1'b1;
        select      = 3'd5;
        data_in     = 8'h3C;
        wait_accept(a1);
        select      = 3'd6;
        data_in     = 8'h7E;
        wait_accept(a2);
        write_valid = 1'b0;
        chk("accept_spacing", a2 - a1, 2 + S);
        @(posedge clk);
        #1;
        chk("stall_strobe6", {24'b0, load_strobe}, 32'h40);
        chk("stall_dout5", {24'b0, dout[5]}, 32'h3C);
        chk("stall_dout6", {24'b0, dout[6]}, 32'h7E);
        repeat (S + 1) @(posedge clk);
        #1;

        // Reset in the COMMIT cycle discards the pending write.
        write_valid = 1'b1;
        select      = 3'd7;
        data_in     = 8'hFF;
        wait_accept(a1);
        write_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, write_ready}, 32'd0);
        chk("midrst_dout7", {24'b0, dout[7]}, 32'd0);
        chk("midrst_dout0", {24'b0, dout[0]}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_no_strobe", {24'b0, load_strobe}, 32'd0);
        chk("midrst_dout7_held", {24'b0, dout[7]}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_midrst", {31'b0, write_ready}, 32'd1);

`ifdef DEMUX_BROADCAST_EN
        broadcast   = 1'b1;
        write_valid = 1'b1;
        select      = 3'd2;
        data_in     = 8'h5A;
        wait_accept(a1);
        write_valid = 1'b0;
        broadcast   = 1'b0;
        @(posedge clk);
        #1;
        chk("bcast_strobe", {24'b0, load_strobe}, 32'hFF);
        for (int i = 0; i < 8; i++) chk($sformatf("bcast_dout%0d", i), {24'b0, dout[i]}, 32'h5A);
        @(posedge clk);
        #1;
        chk("bcast_strobe_cleared", {24'b0, load_strobe}, 32'd0);
`endif

        // Random traffic; requester keeps a request stable until it is taken.
        took = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (!write_valid || took) begin
                write_valid = ($urandom_range(0, 3) != 0);
                select      = 3'($urandom_range(0, 7));
                data_in     = 8'($urandom);
`ifdef DEMUX_BROADCAST_EN
                broadcast   = ($urandom_range(0, 5) == 0);
`endif
            end
            r = write_ready;
            @(posedge clk);
            #1;
            took = write_valid && r;
        end
        write_valid = 1'b0;
        repeat (S + 3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
